ifetch_ctrl: RTL and testbench
==============================

// Module: ifetch_ctrl
// PURPOSE
//  Sequences instruction fetch from the word-addressed instruction memory.
//  Owns the PC, issues in-order read requests and buffers returned words in a
//  small prefetch FIFO. Presents {pc, instruction} to decode via valid/ready.
//  Handles redirects (branch/jump) by flushing the FIFO and discarding in-flight responses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  FIFO_DEPTH  2              prefetch entries, power of 2, >=2; also max requests in flight
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   synchronous, active-high
//  mem_req_valid   out  1   read request to imem
//  mem_req_ready   in   1   imem accepts request this cycle
//  mem_req_addr    out  32  byte address, bits [1:0] always 0
//  mem_rsp_valid   in   1   read data valid; in order, >=1 cycle after accept
//  mem_rsp_data    in   32  instruction word
//  redirect_valid  in   1   1-cycle pulse: new fetch target
//  redirect_pc     in   32  target; bits [1:0] forced to 0
//  inst_valid      out  1   FIFO head valid toward decode
//  inst_ready      in   1   decode consumes head
//  inst_pc         out  32  PC of head instruction
//  inst_code       out  32  head instruction word
// BEHAVIOUR
//  - Reset (sync, while reset=1 at edge): fetch_pc<=RESET_PC, FIFO empty,
//    outstanding=0, drop=0, state<=RUN. Outputs: mem_req_valid=0, inst_valid=0,
//    mem_req_addr=RESET_PC, inst_pc=0, inst_code=0 (0 whenever FIFO empty).
//    Reset mid-operation: all state lost; responses to pre-reset requests are
//    discarded (drop<=outstanding is NOT carried, imem is assumed reset alongside).
//  - Credit rule: mem_req_valid = (state==RUN) && (count+outstanding < FIFO_DEPTH)
//    && !redirect_valid. mem_req_addr = fetch_pc (combinational from register).
//  - Accept (valid&&ready): fetch_pc<=fetch_pc+4 (wraps 32'hFFFF_FFFC->0),
//    outstanding++. Request PC is pushed into a PC-tag queue (depth FIFO_DEPTH).
//  - Response: if drop>0 -> discard, drop--, outstanding--, pop tag. Else push
//    {tag_pc, data} into FIFO, outstanding--. Never overflows by credit rule.
//  - Same-cycle accept+response: outstanding unchanged; count updates independently.
//  - Decode handshake: pop when inst_valid&&inst_ready; output valid the cycle
//    after push (registered FIFO, min latency accept->inst_valid = imem latency+1).
//    Same-cycle push+pop on full FIFO legal; on empty FIFO data is not bypassed.
//  - Redirect (highest priority, wins over accept/pop/push same cycle):
//    FIFO cleared, tag queue cleared, drop<=outstanding - (rsp arriving this cycle ? 1:0),
//    fetch_pc<=redirect_pc&~3, no request issued this cycle. If drop'>0
//    state<=FLUSH else stays RUN.
//  - FSM: RUN   -- issue per credit rule; FLUSH -- no issue, discard
//    responses; FLUSH->RUN when drop reaches 0 (first new request next cycle).
//    Redirect during FLUSH: drop recomputed as above, fetch_pc replaced.
//  - inst_valid never asserted in FLUSH. drop,outstanding width clog2(FIFO_DEPTH)+1.
//  - Assertions: outstanding<=FIFO_DEPTH; no rsp when outstanding==0.
// STRUCTURE
//  - rv32i_pkg: typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;},
//    enum fetch_state_e {FS_RUN, FS_FLUSH}, localparam NOP_INST=32'h0000_0013.
//  - One sub-module: sync_fifo #(.T(fetch_entry_t), .DEPTH) with push/pop/
//    clear/full/empty/count; instantiated for both prefetch FIFO and PC tags.
// TESTING
//  1. Reset, ready=1, 1-cycle imem, inst_ready=1 -> addrs 0,4,8,...; inst_pc 0,4,8
//     with code matching mem[0..]; first inst_valid 2 cycles after reset release.
//  2. inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH(2) requests issued, then
//     mem_req_valid=0; release -> inst_pc 0,4 delivered, fetch resumes at 8.
//  3. mem_req_ready=0 for 5 cycles -> mem_req_addr held at 0, no PC advance.
//  4. 3-cycle imem, redirect_pc=32'h40 with 2 requests in flight -> both responses
//     dropped, FLUSH for remaining latency, next inst_pc=0x40, no stale inst_valid.
//  5. redirect same cycle as FIFO pop and rsp_valid -> pop ignored, rsp dropped,
//     next request addr = redirect_pc; redirect_pc=0x43 -> addr 0x40.
//  6. fetch_pc=32'hFFFF_FFFC -> next addr 0; reset asserted mid-FLUSH -> addr
//     RESET_PC, inst_valid=0, outstanding=0 next cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types for the instruction-fetch slice: the prefetch entry layout and
// the fetch controller state encoding.
package rv32i_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   typedef enum logic {
      FS_RUN   = 1'b0,
      FS_FLUSH = 1'b1
   } fetch_state_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered write and a combinational head view.
// Used for both the prefetch buffer and the in-flight request PC tags.
module sync_fifo
   import rv32i_pkg::*;
#(
   parameter type T     = logic [31:0],
   parameter int  DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  T                         push_data,
   input  logic                     pop,
   output T                         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign head    = mem[rd_ptr_reg];
   assign do_pop  = pop && !empty && !clear;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && !clear && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, keeps at most FIFO_DEPTH words in
// flight or buffered, and discards responses that belong to a redirected path.
module ifetch_ctrl
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_code
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e  state_reg, state_next;
   logic [31:0]   fetch_pc_reg, fetch_pc_next;
   logic [CW-1:0] outstanding_reg, outstanding_next;
   logic [CW-1:0] drop_reg, drop_next;

   logic          req_fire, rsp_keep;
   logic          fifo_push, fifo_pop, tag_push, tag_pop;
   fetch_entry_t  fifo_head, fifo_wdata;
   logic          fifo_full, fifo_empty, tag_full, tag_empty;
   logic [CW-1:0] fifo_count, tag_count;
   logic [31:0]   tag_head;
   logic [CW:0]   credit_used;

   // Buffered words plus in-flight requests may never exceed the buffer size.
   assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_reg};
   assign req_fire    = mem_req_valid && mem_req_ready;
   assign rsp_keep    = mem_rsp_valid && (drop_reg == '0);
   assign fifo_push   = rsp_keep && !redirect_valid;
   assign fifo_pop    = inst_valid && inst_ready && !redirect_valid;
   assign tag_push    = req_fire;
   assign tag_pop     = rsp_keep && !redirect_valid;
   assign fifo_wdata  = '{pc: tag_head, inst: mem_rsp_data};

   sync_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) u_prefetch (
      .clk(clk), .reset(reset), .clear(redirect_valid),
      .push(fifo_push), .push_data(fifo_wdata), .pop(fifo_pop), .head(fifo_head),
      .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
   );

   sync_fifo #(.T(logic [31:0]), .DEPTH(FIFO_DEPTH)) u_tags (
      .clk(clk), .reset(reset), .clear(redirect_valid),
      .push(tag_push), .push_data(fetch_pc_reg), .pop(tag_pop), .head(tag_head),
      .full(tag_full), .empty(tag_empty), .count(tag_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= FS_RUN;
         fetch_pc_reg    <= RESET_PC;
         outstanding_reg <= '0;
         drop_reg        <= '0;
      end else begin
         state_reg       <= state_next;
         fetch_pc_reg    <= fetch_pc_next;
         outstanding_reg <= outstanding_next;
         drop_reg        <= drop_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      fetch_pc_next    = fetch_pc_reg;
      outstanding_next = outstanding_reg;
      drop_next        = drop_reg;
      if (req_fire && !mem_rsp_valid)      outstanding_next = outstanding_reg + CW'(1);
      else if (!req_fire && mem_rsp_valid) outstanding_next = outstanding_reg - CW'(1);
      if (req_fire) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         drop_next     = outstanding_reg - CW'(mem_rsp_valid);
         fetch_pc_next = {redirect_pc[31:2], 2'b00};
         state_next    = (drop_next != '0) ? FS_FLUSH : FS_RUN;
      end else begin
         if (mem_rsp_valid && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
         if ((state_reg == FS_FLUSH) && (drop_next == '0)) state_next = FS_RUN;
      end
   end

   always_comb begin
      mem_req_valid = !reset && (state_reg == FS_RUN) && !redirect_valid &&
                      (credit_used < (CW+1)'(FIFO_DEPTH));
      mem_req_addr  = fetch_pc_reg;
      inst_valid    = !reset && (state_reg == FS_RUN) && !fifo_empty;
      inst_pc       = inst_valid ? fifo_head.pc   : '0;
      inst_code     = inst_valid ? fifo_head.inst : '0;
   end

   a_out_bound: assert property (@(posedge clk) disable iff (reset)
      outstanding_reg <= CW'(FIFO_DEPTH));
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
      mem_rsp_valid |-> (outstanding_reg != '0));
   a_tag_track: assert property (@(posedge clk) disable iff (reset)
      tag_count == (outstanding_reg - drop_reg));
   a_tag_room: assert property (@(posedge clk) disable iff (reset)
      !(tag_push && tag_full));
   a_tag_avail: assert property (@(posedge clk) disable iff (reset)
      tag_pop |-> !tag_empty);
   a_fifo_room: assert property (@(posedge clk) disable iff (reset)
      !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scenario bench for ifetch_ctrl with a variable-latency imem model and an
// in-order scoreboard of expected {pc, instruction} deliveries.
module tb_ifetch_ctrl;
   import rv32i_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0, reset = 1'b1;
   logic        mem_req_valid, mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid, inst_ready = 1'b0;
   logic [31:0] inst_pc, inst_code;

   int err_cnt = 0, chk_cnt = 0, acc_cnt = 0, dlv_cnt = 0, cyc = 0, lat = 1;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   pend_t        pend_q[$];
   fetch_entry_t exp_q[$];
   logic [31:0]  model_pc = RESET_PC;

   ifetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_pc(inst_pc), .inst_code(inst_code)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ NOP_INST;
   endfunction

   // imem: in-order responses, one per cycle, 'lat' cycles after acceptance.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = mem_word(pend_q[0].addr);
         pend_q.delete(0);
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = '0;
      end
   end

   // Mid-cycle monitor: scoreboard push on accepted request, pop on delivery.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         pend_q.delete();
         model_pc = RESET_PC;
      end else if (redirect_valid) begin
         chk_cnt++;
         if (mem_req_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL redirect_no_req got=%b exp=0", mem_req_valid);
         end
         exp_q.delete();
         model_pc = redirect_pc & ~32'h3;
      end else begin
         if (inst_valid && inst_ready) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
               err_cnt++;
               $display("FAIL stale_inst got pc=%08h exp=no delivery", inst_pc);
            end else begin
               fetch_entry_t e;
               e = exp_q.pop_front();
               $display("tx deliver pc=%08h code=%08h", inst_pc, inst_code);
               if (inst_pc !== e.pc || inst_code !== e.inst) begin
                  err_cnt++;
                  $display("FAIL deliver got=%08h/%08h exp=%08h/%08h", inst_pc, inst_code, e.pc, e.inst);
               end
            end
            dlv_cnt++;
         end
         if (mem_req_valid && mem_req_ready) begin
            chk_cnt++;
            if (mem_req_addr !== model_pc) begin
               err_cnt++;
               $display("FAIL req_addr got=%08h exp=%08h", mem_req_addr, model_pc);
            end
            exp_q.push_back('{pc: model_pc, inst: mem_word(model_pc)});
            pend_q.push_back('{addr: model_pc, due: cyc + lat});
            model_pc = model_pc + 32'd4;
            acc_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic do_reset(input int n);
      tick();
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      tick();
      mem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1; redirect_valid = 1'b0; reset = 1'b1;
      repeat (2) tick();
      sample();
      chk_cnt++; if (mem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
      chk_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
      chk_cnt++; if (mem_req_addr !== RESET_PC) begin err_cnt++; $display("FAIL reset_addr got=%08h exp=%08h", mem_req_addr, RESET_PC); end
      chk_cnt++; if (inst_pc !== 32'h0 || inst_code !== 32'h0) begin err_cnt++; $display("FAIL reset_inst got=%08h/%08h exp=0/0", inst_pc, inst_code); end
      tick();
      reset = 1'b0;
      n = 0;
      sample();
      while (!inst_valid && n < 10) begin tick(); n++; sample(); end
      chk_cnt++; if (n !== 2) begin err_cnt++; $display("FAIL first_latency got=%0d exp=2", n); end
      chk_cnt++; if (inst_pc !== RESET_PC || inst_code !== mem_word(RESET_PC)) begin
         err_cnt++; $display("FAIL first_inst got=%08h/%08h exp=%08h/%08h", inst_pc, inst_code, RESET_PC, mem_word(RESET_PC));
      end
   endtask

   task automatic test_stream();
      int base;
      base = dlv_cnt;
      repeat (20) tick();
      chk_cnt++; if (dlv_cnt - base < 4) begin err_cnt++; $display("FAIL stream_count got=%0d exp>=4", dlv_cnt - base); end
   endtask

   task automatic test_backpressure();
      int base, n;
      inst_ready = 1'b0;
      do_reset(2);
      base = acc_cnt;
      repeat (10) tick();
      sample();
      chk_cnt++; if (acc_cnt - base !== DEPTH) begin err_cnt++; $display("FAIL bp_requests got=%0d exp=%0d", acc_cnt - base, DEPTH); end
      chk_cnt++; if (mem_req_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_req_valid got=%b exp=0", mem_req_valid); end
      chk_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin err_cnt++; $display("FAIL bp_head got=%b/%08h exp=1/00000000", inst_valid, inst_pc); end
      chk_cnt++; if (mem_req_addr !== 32'h8) begin err_cnt++; $display("FAIL bp_addr got=%08h exp=00000008", mem_req_addr); end
      tick();
      inst_ready = 1'b1;
      n = 0;
      sample();
      while (!mem_req_valid && n < 10) begin tick(); n++; sample(); end
      chk_cnt++; if (!mem_req_valid || mem_req_addr !== 32'h8) begin err_cnt++; $display("FAIL bp_resume got=%b/%08h exp=1/00000008", mem_req_valid, mem_req_addr); end
      repeat (6) tick();
   endtask

   task automatic test_req_stall();
      mem_req_ready = 1'b0;
      do_reset(2);
      for (int i = 0; i < 5; i++) begin
         sample();
         chk_cnt++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
            err_cnt++; $display("FAIL req_hold[%0d] got=%b/%08h exp=1/%08h", i, mem_req_valid, mem_req_addr, RESET_PC);
         end
         tick();
      end
      mem_req_ready = 1'b1;
      repeat (8) tick();
   endtask

   task automatic test_redirect_flush();
      int base, n;
      lat = 3;
      do_reset(2);
      base = acc_cnt;
      n = 0;
      while (acc_cnt < base + 2 && n < 10) begin tick(); n++; end
      chk_cnt++; if (acc_cnt - base !== 2) begin err_cnt++; $display("FAIL rf_inflight got=%0d exp=2", acc_cnt - base); end
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      sample();
      for (int i = 0; i < 2; i++) begin
         tick();
         redirect_valid = 1'b0;
         sample();
         chk_cnt++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            err_cnt++; $display("FAIL rf_flush[%0d] got=%b/%b exp=0/0", i, mem_req_valid, inst_valid);
         end
      end
      tick();
      sample();
      chk_cnt++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin
         err_cnt++; $display("FAIL rf_restart got=%b/%08h exp=1/00000040", mem_req_valid, mem_req_addr);
      end
      n = 0;
      while (!inst_valid && n < 20) begin tick(); n++; sample(); end
      chk_cnt++; if (inst_pc !== 32'h40 || inst_code !== mem_word(32'h40)) begin
         err_cnt++; $display("FAIL rf_first got=%08h/%08h exp=00000040/%08h", inst_pc, inst_code, mem_word(32'h40));
      end
   endtask

   task automatic test_redirect_same_cycle();
      int n;
      bit found;
      lat = 1;
      do_reset(2);
      n = 0; found = 1'b0;
      while (!found && n < 20) begin
         tick(); #1;
         if (inst_valid && mem_rsp_valid) found = 1'b1;
         n++;
      end
      chk_cnt++; if (!found) begin err_cnt++; $display("FAIL rs_setup got=0 exp=1"); end
      redirect_valid = 1'b1; redirect_pc = 32'h43;
      sample();
      tick();
      redirect_valid = 1'b0;
      sample();
      chk_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL rs_cleared got=%b exp=0", inst_valid); end
      chk_cnt++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h40) begin
         err_cnt++; $display("FAIL rs_addr got=%b/%08h exp=1/00000040", mem_req_valid, mem_req_addr);
      end
      n = 0;
      while (!inst_valid && n < 20) begin tick(); n++; sample(); end
      chk_cnt++; if (inst_pc !== 32'h40) begin err_cnt++; $display("FAIL rs_first got=%08h exp=00000040", inst_pc); end
   endtask

   task automatic test_wrap_reset();
      int n;
      bit found;
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      n = 0;
      sample();
      while (!(mem_req_valid && mem_req_ready) && n < 20) begin tick(); n++; sample(); end
      chk_cnt++; if (mem_req_addr !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL wrap_first got=%08h exp=fffffffc", mem_req_addr); end
      tick();
      n = 0;
      sample();
      while (!(mem_req_valid && mem_req_ready) && n < 20) begin tick(); n++; sample(); end
      chk_cnt++; if (mem_req_addr !== 32'h0) begin err_cnt++; $display("FAIL wrap_next got=%08h exp=00000000", mem_req_addr); end
      lat = 3;
      repeat (6) tick();
      n = 0; found = 1'b0;
      while (!found && n < 20) begin
         tick(); #1;
         if (pend_q.size() >= 2 && !mem_rsp_valid) found = 1'b1;
         n++;
      end
      chk_cnt++; if (!found) begin err_cnt++; $display("FAIL wr_setup got=0 exp=1"); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      sample();
      chk_cnt++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         err_cnt++; $display("FAIL wr_flush got=%b/%b exp=0/0", mem_req_valid, inst_valid);
      end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sample();
      chk_cnt++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin
         err_cnt++; $display("FAIL wr_after_reset got=%b/%08h exp=1/%08h", mem_req_valid, mem_req_addr, RESET_PC);
      end
      chk_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL wr_reset_inst got=%b exp=0", inst_valid); end
      tick();
      sample();
      chk_cnt++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC + 32'd4) begin
         err_cnt++; $display("FAIL wr_credit got=%b/%08h exp=1/%08h", mem_req_valid, mem_req_addr, RESET_PC + 32'd4);
      end
      n = 0;
      while (!inst_valid && n < 20) begin tick(); n++; sample(); end
      chk_cnt++; if (inst_pc !== RESET_PC) begin err_cnt++; $display("FAIL wr_first got=%08h exp=%08h", inst_pc, RESET_PC); end
      repeat (6) tick();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_req_stall();
      test_redirect_flush();
      test_redirect_same_cycle();
      test_wrap_reset();
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
